// File: rtl/r200_id_pipe.sv
// Decode/operand-fetch stage: RV decode, NREG x XLEN register file with write-through, one output register.
// Latency 1 cycle; stalls fetch while the output is held or on a load-use hazard; flush kills held and incoming.
module r200_id_pipe #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instrn,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pcp4,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic            wb_regwr,
   input  logic [4:0]      wb_rdaddr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [XLEN-1:0] out_rs2o,
   output logic [XLEN-1:0] out_brtarg,
   output logic [4:0]      out_rdaddr,
   output logic            out_regwr,
   output logic            out_memwr,
   output logic            out_isload,
   output logic            out_isbr,
   output logic            out_jal,
   output logic            out_alu_alt,
   output logic            out_illegal,
   output logic [1:0]      out_wbsel
);

   localparam int AW = $clog2(NREG);

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] rs2o;
      logic [XLEN-1:0] brtarg;
      logic [4:0]      rdaddr;
      logic            regwr;
      logic            memwr;
      logic            isload;
      logic            isbr;
      logic            jal;
      logic            alu_alt;
      logic            illegal;
      logic [1:0]      wbsel;
   } id_out_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [XLEN-1:0] gpr_q [NREG];
   id_out_t         out_q, out_d;
   logic            valid_q, valid_d;

   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui;
   logic        known, uses_rs1, uses_rs2, writes_rd, bad_reg, illegal;
   logic        hz_rs1, hz_rs2, hazard, accept;
   logic [31:0] imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign opc = instrn[6:0];
   assign rd  = instrn[11:7];
   assign f3  = instrn[14:12];
   assign rs1 = instrn[19:15];
   assign rs2 = instrn[24:20];

   assign is_r   = (opc == 7'b0110011);
   assign is_i   = (opc == 7'b0010011);
   assign is_ld  = (opc == 7'b0000011);
   assign is_st  = (opc == 7'b0100011);
   assign is_br  = (opc == 7'b1100011);
   assign is_jal = (opc == 7'b1101111);
   assign is_lui = (opc == 7'b0110111);

   assign known     = is_r | is_i | is_ld | is_st | is_br | is_jal | is_lui;
   assign uses_rs1  = is_r | is_i | is_ld | is_st | is_br;
   assign uses_rs2  = is_r | is_st | is_br;
   assign writes_rd = is_r | is_i | is_ld | is_jal | is_lui;
   assign bad_reg   = (uses_rs1 && int'(rs1) >= NREG) || (uses_rs2 && int'(rs2) >= NREG)
                   || (writes_rd && int'(rd) >= NREG);
   assign illegal   = !known || bad_reg;

   assign imm_i32 = {{20{instrn[31]}}, instrn[31:20]};
   assign imm_s32 = {{20{instrn[31]}}, instrn[31:25], instrn[11:7]};
   assign imm_b32 = {{19{instrn[31]}}, instrn[31], instrn[7], instrn[30:25], instrn[11:8], 1'b0};
   assign imm_j32 = {{11{instrn[31]}}, instrn[31], instrn[19:12], instrn[20], instrn[30:21], 1'b0};
   assign imm_u32 = {instrn[31:12], 12'b0};

   // Write-through: a register being written this cycle reads as the new value.
   always_comb begin
      rs1_val = '0;
      if (rs1 != 5'd0 && int'(rs1) < NREG) begin
         if (wb_regwr && wb_rdaddr == rs1) rs1_val = wb_data;
         else                              rs1_val = gpr_q[rs1[AW-1:0]];
      end
   end

   always_comb begin
      rs2_val = '0;
      if (rs2 != 5'd0 && int'(rs2) < NREG) begin
         if (wb_regwr && wb_rdaddr == rs2) rs2_val = wb_data;
         else                              rs2_val = gpr_q[rs2[AW-1:0]];
      end
   end

   // Load-use: the loaded value is not available until the load has left execute.
   assign hz_rs1   = !is_lui && !is_jal && (rs1 == out_q.rdaddr);
   assign hz_rs2   = uses_rs2 && (rs2 == out_q.rdaddr);
   assign hazard   = in_valid && !flush && valid_q && out_q.isload && (out_q.rdaddr != 5'd0)
                  && (hz_rs1 || hz_rs2);
   assign in_ready = flush || ((!valid_q || ex_ready) && !hazard);
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      out_d         = '0;
      out_d.rs2o    = rs2_val;
      out_d.illegal = illegal;
      out_d.isload  = is_ld;
      out_d.isbr    = is_br;
      out_d.jal     = is_jal;
      out_d.op1     = (is_lui || is_jal) ? '0 : rs1_val;
      if (is_r || is_br)      out_d.op2 = rs2_val;
      else if (is_i || is_ld) out_d.op2 = sext32(imm_i32);
      else if (is_st)         out_d.op2 = sext32(imm_s32);
      else if (is_lui)        out_d.op2 = sext32(imm_u32);
      else if (is_jal)        out_d.op2 = pcp4;
      if (is_br)       out_d.brtarg = pc + sext32(imm_b32);
      else if (is_jal) out_d.brtarg = pc + sext32(imm_j32);
      out_d.alu_alt = instrn[30] && (is_r || (is_i && f3 == 3'b101));
      if (writes_rd) out_d.rdaddr = rd;
      out_d.regwr   = writes_rd && (rd != 5'd0) && !illegal;
      out_d.memwr   = is_st && !illegal;
      out_d.wbsel   = is_jal ? 2'b10 : (is_ld ? 2'b01 : 2'b00);
   end

   always_comb begin
      valid_d = valid_q;
      if (flush)         valid_d = 1'b0;
      else if (accept)   valid_d = 1'b1;
      else if (ex_ready) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         valid_q <= valid_d;
         if (accept) out_q <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      end else if (wb_regwr && wb_rdaddr != 5'd0 && int'(wb_rdaddr) < NREG) begin
         gpr_q[wb_rdaddr[AW-1:0]] <= wb_data;
      end
   end

   assign out_valid   = valid_q;
   assign out_op1     = out_q.op1;
   assign out_op2     = out_q.op2;
   assign out_rs2o    = out_q.rs2o;
   assign out_brtarg  = out_q.brtarg;
   assign out_rdaddr  = out_q.rdaddr;
   assign out_regwr   = out_q.regwr;
   assign out_memwr   = out_q.memwr;
   assign out_isload  = out_q.isload;
   assign out_isbr    = out_q.isbr;
   assign out_jal     = out_q.jal;
   assign out_alu_alt = out_q.alu_alt;
   assign out_illegal = out_q.illegal;
   assign out_wbsel   = out_q.wbsel;

endmodule

// File: tb/tb_r200_id_pipe.sv
// Directed bench for r200_id_pipe: default instance plus an NREG=16 instance sharing the same stimulus.
module tb_r200_id_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, ex_ready, wb_regwr;
   logic [31:0] instrn, pc, pcp4, wb_data;
   logic [4:0]  wb_rdaddr;

   logic        in_ready, out_valid, out_regwr, out_memwr, out_isload, out_isbr, out_jal, out_alu_alt, out_illegal;
   logic [31:0] out_op1, out_op2, out_rs2o, out_brtarg;
   logic [4:0]  out_rdaddr;
   logic [1:0]  out_wbsel;

   logic        e_in_ready, e_valid, e_regwr, e_memwr, e_isload, e_isbr, e_jal, e_alu_alt, e_illegal;
   logic [31:0] e_op1, e_op2, e_rs2o, e_brtarg;
   logic [4:0]  e_rdaddr;
   logic [1:0]  e_wbsel;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   r200_id_pipe #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instrn(instrn), .pc(pc), .pcp4(pcp4),
      .flush(flush), .ex_ready(ex_ready), .wb_regwr(wb_regwr), .wb_rdaddr(wb_rdaddr), .wb_data(wb_data),
      .out_valid(out_valid), .out_op1(out_op1), .out_op2(out_op2), .out_rs2o(out_rs2o), .out_brtarg(out_brtarg),
      .out_rdaddr(out_rdaddr), .out_regwr(out_regwr), .out_memwr(out_memwr), .out_isload(out_isload),
      .out_isbr(out_isbr), .out_jal(out_jal), .out_alu_alt(out_alu_alt), .out_illegal(out_illegal),
      .out_wbsel(out_wbsel)
   );

   r200_id_pipe #(.XLEN(32), .NREG(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .instrn(instrn), .pc(pc), .pcp4(pcp4),
      .flush(flush), .ex_ready(ex_ready), .wb_regwr(wb_regwr), .wb_rdaddr(wb_rdaddr), .wb_data(wb_data),
      .out_valid(e_valid), .out_op1(e_op1), .out_op2(e_op2), .out_rs2o(e_rs2o), .out_brtarg(e_brtarg),
      .out_rdaddr(e_rdaddr), .out_regwr(e_regwr), .out_memwr(e_memwr), .out_isload(e_isload),
      .out_isbr(e_isbr), .out_jal(e_jal), .out_alu_alt(e_alu_alt), .out_illegal(e_illegal),
      .out_wbsel(e_wbsel)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] addr);
      in_valid = 1'b1;
      instrn   = ins;
      pc       = addr;
      pcp4     = addr + 32'd4;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      wb_regwr = 1'b0; wb_rdaddr = 5'd0; wb_data = '0; instrn = '0; pc = '0; pcp4 = '0;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_op1", out_op1, 0);
      chk("rst_regwr", out_regwr, 0);
      rst = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);

      // x5 = 0x1234 through the write port, then ADDI x6,x5,-1
      wb_regwr = 1'b1; wb_rdaddr = 5'd5; wb_data = 32'h1234;
      tick();
      wb_regwr = 1'b0;
      offer(32'hFFF28313, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("addi_valid", out_valid, 1);
      chk("addi_op1", out_op1, 32'h1234);
      chk("addi_op2", out_op2, 32'hFFFFFFFF);
      chk("addi_regwr", out_regwr, 1);
      chk("addi_rd", out_rdaddr, 6);
      chk("addi_illegal", out_illegal, 0);
      tick();
      chk("drain_valid", out_valid, 0);

      // ADD x4,x3,x0 while x3 <= 0xAA in the same cycle
      wb_regwr = 1'b1; wb_rdaddr = 5'd3; wb_data = 32'hAA;
      offer(32'h00018233, 32'h8);
      tick();
      wb_regwr = 1'b0;
      chk("bypass_op1", out_op1, 32'hAA);
      chk("bypass_rd", out_rdaddr, 4);

      // LW x7,0(x1) then ADD x8,x7,x2: one bubble
      offer(32'h0000A383, 32'hC);
      tick();
      chk("lw_isload", out_isload, 1);
      chk("lw_wbsel", out_wbsel, 2'b01);
      chk("lw_rd", out_rdaddr, 7);
      offer(32'h00238433, 32'h10);
      #1 chk("hazard_in_ready", in_ready, 0);
      tick();
      chk("bubble_valid", out_valid, 0);
      chk("after_bubble_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("dep_valid", out_valid, 1);
      chk("dep_rd", out_rdaddr, 8);

      // Three stall cycles, then flush kills held and offered instruction
      ex_ready = 1'b0;
      offer(32'h800004B7, 32'h14);
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_in_ready", in_ready, 0);
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_rd", out_rdaddr, 8);
      end
      flush = 1'b1;
      #1 chk("flush_in_ready", in_ready, 1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);

      // LUI x9,0x80000
      ex_ready = 1'b1;
      offer(32'h800004B7, 32'h20);
      tick();
      chk("lui_valid", out_valid, 1);
      chk("lui_op1", out_op1, 0);
      chk("lui_op2", out_op2, 32'h80000000);
      chk("lui_rd", out_rdaddr, 9);

      // JAL x1,+16 at 0x200
      offer(32'h010000EF, 32'h200);
      tick();
      chk("jal_targ", out_brtarg, 32'h210);
      chk("jal_op2", out_op2, 32'h204);
      chk("jal_wbsel", out_wbsel, 2'b10);
      chk("jal_flag", out_jal, 1);

      // SW x5,-4(x6)
      offer(32'hFE532E23, 32'h204);
      tick();
      chk("sw_op2", out_op2, 32'hFFFFFFFC);
      chk("sw_rs2o", out_rs2o, 32'h1234);
      chk("sw_memwr", out_memwr, 1);
      chk("sw_regwr", out_regwr, 0);

      // SRAI x10,x5,3
      offer(32'h4032D513, 32'h208);
      tick();
      chk("srai_alt", out_alu_alt, 1);
      chk("srai_op2", out_op2, 32'h403);
      chk("srai_op1", out_op1, 32'h1234);

      // BEQ x1,x2,-8 at 0x100
      offer(32'hFE208CE3, 32'h100);
      tick();
      chk("beq_targ", out_brtarg, 32'hF8);
      chk("beq_isbr", out_isbr, 1);
      chk("beq_regwr", out_regwr, 0);

      // ADD x20,x1,x2: legal with 32 GPRs, illegal with 16
      offer(32'h00208A33, 32'h104);
      tick();
      chk("add20_ill32", out_illegal, 0);
      chk("add20_ill16", e_illegal, 1);
      chk("add20_regwr16", e_regwr, 0);

      // Unknown opcode
      offer(32'h0000000B, 32'h108);
      tick();
      in_valid = 1'b0;
      chk("unk_illegal", out_illegal, 1);
      chk("unk_regwr", out_regwr, 0);

      // Reset in the middle of a stall
      ex_ready = 1'b0;
      tick();
      chk("prerst_valid", out_valid, 1);
      rst = 1'b1;
      offer(32'hFFF28313, 32'h10C);
      tick();
      rst = 1'b0;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_op1", out_op1, 0);
      #1 chk("midrst_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("postrst_valid", out_valid, 1);
      chk("postrst_x5", out_op1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
